// File: rtl/lcd_frame_capture.sv
// LCD pixel stream capture: packs 2-bit shades four to a byte and writes them to a framebuffer.
// Optional macro LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN adds a toggling write page and display_page.
module lcd_frame_capture #(
  parameter int unsigned WIDTH  = 160,
  parameter int unsigned HEIGHT = 144
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [1:0]  pixel_data,
  input  logic        pixel_latch,
  input  logic        hsync,
  input  logic        vsync,
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
  output logic [13:0] fb_A,
  output logic        display_page,
`else
  output logic [12:0] fb_A,
`endif
  output logic [7:0]  fb_Do,
  output logic        fb_wr_n,
  output logic        fb_cs_n,
  output logic        frame_done,
  output logic        sync_err
);

`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
  localparam int unsigned FbAW = 14;
`else
  localparam int unsigned FbAW = 13;
`endif
  localparam int unsigned AW = 13;
  localparam int unsigned XW = $clog2(WIDTH + 1);
  // One extra count above HEIGHT so an hsync past the last line is distinguishable at vsync.
  localparam int unsigned YW = $clog2(HEIGHT + 2);

  localparam logic [XW-1:0] XMax      = XW'(WIDTH);
  localparam logic [YW-1:0] YMax      = YW'(HEIGHT);
  localparam logic [AW-1:0] LineWords = AW'(WIDTH / 4);

  typedef enum logic {StWaitVsync, StActive} state_e;

  state_e           state_q, state_d;
  logic             hs_prev_q, vs_prev_q;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [AW-1:0]    base_q, base_d;
  logic [5:0]       grp_q, grp_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [FbAW-1:0]  fb_a_q, fb_a_d;
  logic [7:0]       fb_do_q, fb_do_d;
  logic             wr_q, wr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             page_q, page_d;
  logic             disp_q, disp_d;
  logic             hs_rise, vs_rise;

  assign hs_rise = hsync & ~hs_prev_q;
  assign vs_rise = vsync & ~vs_prev_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    base_d  = base_q;
    grp_d   = grp_q;
    cnt_d   = cnt_q;
    fb_a_d  = fb_a_q;
    fb_do_d = fb_do_q;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q;
    page_d  = page_q;
    disp_d  = disp_q;

    unique case (state_q)
      StWaitVsync: begin
        if (vs_rise) begin
          state_d = StActive;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          base_d  = '0;
          grp_d   = '0;
          cnt_d   = '0;
        end
      end
      StActive: begin
        // The pixel is handled first so a coincident sync edge sees it as part of this line.
        if (pixel_latch) begin
          if ((y_q >= YMax) || (x_q >= XMax)) begin
            err_d = 1'b1;
          end else begin
            grp_d = {grp_q[3:0], pixel_data};
            cnt_d = cnt_q + 2'd1;
            x_d   = x_q + XW'(1);
            if (cnt_q == 2'd3) begin
              wr_d    = 1'b1;
              fb_do_d = {grp_q, pixel_data};
              addr_d  = addr_q + AW'(1);
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
              fb_a_d  = {page_q, addr_q};
`else
              fb_a_d  = addr_q;
`endif
            end
          end
        end

        if (vs_rise) begin
          if (y_q == YMax) begin
            done_d = 1'b1;
            disp_d = page_q;
            page_d = ~page_q;
          end else begin
            err_d = 1'b1;
          end
          x_d    = '0;
          y_d    = '0;
          addr_d = '0;
          base_d = '0;
          grp_d  = '0;
          cnt_d  = '0;
        end else if (hs_rise) begin
          if (x_d != XMax) begin
            err_d = 1'b1;
          end
          x_d   = '0;
          grp_d = '0;
          cnt_d = '0;
          if (y_q < YMax) begin
            y_d    = y_q + YW'(1);
            base_d = base_q + LineWords;
            addr_d = base_q + LineWords;
          end else if (y_q == YMax) begin
            y_d = y_q + YW'(1);
          end
        end
      end
      default: state_d = StWaitVsync;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StWaitVsync;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      addr_q    <= '0;
      base_q    <= '0;
      grp_q     <= '0;
      cnt_q     <= '0;
      fb_a_q    <= '0;
      fb_do_q   <= '0;
      wr_q      <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      page_q    <= 1'b0;
      disp_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      hs_prev_q <= hsync;
      vs_prev_q <= vsync;
      x_q       <= x_d;
      y_q       <= y_d;
      addr_q    <= addr_d;
      base_q    <= base_d;
      grp_q     <= grp_d;
      cnt_q     <= cnt_d;
      fb_a_q    <= fb_a_d;
      fb_do_q   <= fb_do_d;
      wr_q      <= wr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      page_q    <= page_d;
      disp_q    <= disp_d;
    end
  end

  assign fb_A       = fb_a_q;
  assign fb_Do      = fb_do_q;
  assign fb_wr_n    = ~wr_q;
  assign fb_cs_n    = ~wr_q;
  assign frame_done = done_q;
  assign sync_err   = err_q;
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
  assign display_page = disp_q;
`else
  logic unused_page;
  assign unused_page = page_d ^ disp_d ^ page_q ^ disp_q;
`endif

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Scoreboard bench for lcd_frame_capture: directed pixel streams, expected writes queued and
// popped by a monitor on each framebuffer strobe.
module tb_lcd_frame_capture;

`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
  localparam int TbAW = 14;
`else
  localparam int TbAW = 13;
`endif
  localparam int W = 160;
  localparam int H = 144;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [1:0]      pixel_data = 2'd0;
  logic            pixel_latch = 1'b0;
  logic            hsync = 1'b0;
  logic            vsync = 1'b0;
  logic [TbAW-1:0] fb_A;
  logic [7:0]      fb_Do;
  logic            fb_wr_n, fb_cs_n, frame_done, sync_err;
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
  logic            display_page;
`endif

  lcd_frame_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pixel_data  (pixel_data),
    .pixel_latch (pixel_latch),
    .hsync       (hsync),
    .vsync       (vsync),
    .fb_A        (fb_A),
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
    .display_page(display_page),
`endif
    .fb_Do       (fb_Do),
    .fb_wr_n     (fb_wr_n),
    .fb_cs_n     (fb_cs_n),
    .frame_done  (frame_done),
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;

  logic [TbAW+7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int fd_cnt = 0;
  logic [TbAW-1:0] last_a = '0;
  logic exp_page = 1'b0;

  // Monitor: every strobe must match the oldest expected write.
  always @(negedge clock) begin
    logic [TbAW+7:0] e;
    if (reset_n && !fb_wr_n) begin
      wr_cnt++;
      total++;
      last_a = fb_A;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write actual fb_A=%0h fb_Do=%0h required no write", fb_A, fb_Do);
      end else begin
        e = exp_q.pop_front();
        if ({fb_A, fb_Do} !== e || fb_cs_n !== 1'b0) begin
          bad++;
          $display("FAIL write actual fb_A=%0h fb_Do=%0h cs_n=%0b required fb_A=%0h fb_Do=%0h cs_n=0",
                   fb_A, fb_Do, fb_cs_n, e[TbAW+7:8], e[7:0]);
        end
      end
    end
    if (reset_n && frame_done) fd_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic cyc(input bit l, input logic [1:0] d, input bit h, input bit v);
    @(posedge clock);
    #1;
    pixel_latch = l;
    pixel_data  = d;
    hsync       = h;
    vsync       = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  function automatic logic [1:0] shade(input int x, input int y);
    return 2'((x ^ (x >> 2) ^ y) & 3);
  endfunction

  function automatic logic [TbAW+7:0] mk(input int addr, input logic [7:0] data);
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
    return {exp_page, 13'(addr), data};
`else
    return {13'(addr), data};
`endif
  endfunction

  // hs_mode: 0 no hsync, 1 hsync on last pixel, 2 hsync one cycle after last pixel.
  task automatic drive_line(input int y, input int npix, input int hs_mode, input bit push);
    logic [7:0] acc;
    logic [1:0] s;
    acc = 8'd0;
    for (int x = 0; x < npix; x++) begin
      s   = shade(x, y);
      acc = {acc[5:0], s};
      cyc(1'b1, s, (hs_mode == 1) && (x == npix - 1), 1'b0);
      if (push && (x % 4 == 3) && (x < W) && (y < H)) exp_q.push_back(mk(y * (W / 4) + x / 4, acc));
    end
    if (hs_mode == 2) cyc(1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset_n = 1'b0;
    pixel_latch = 1'b0;
    hsync = 1'b0;
    vsync = 1'b0;
    idle(3);
    reset_n = 1'b1;
  endtask

  initial begin
    // Reset values while reset is held.
    idle(2);
    check("rst_wr_n", 32'(fb_wr_n), 32'd1);
    check("rst_cs_n", 32'(fb_cs_n), 32'd1);
    check("rst_fb_A", 32'(fb_A), 32'd0);
    check("rst_fb_Do", 32'(fb_Do), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_sync_err", 32'(sync_err), 32'd0);
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
    check("rst_display_page", 32'(display_page), 32'd1);
`endif
    reset_n = 1'b1;
    idle(2);

    // Pixels and hsync before any vsync are ignored.
    drive_line(0, W, 2, 1'b0);
    idle(3);
    check("prevsync_sync_err", 32'(sync_err), 32'd0);

    // First group after vsync: shades 3,2,1,0 -> 0xE4 at address 0, strobe one cycle after.
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    cyc(1'b1, 2'd3, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    exp_q.push_back(mk(0, 8'hE4));
    check("strobe_early", 32'(fb_wr_n), 32'd1);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    check("strobe_on", 32'(fb_wr_n), 32'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    check("strobe_off", 32'(fb_wr_n), 32'd1);
    idle(2);
    check("first_group_pending", 32'(exp_q.size()), 32'd0);

    // Full frame; odd lines end with hsync coincident with the 160th pixel, then hsync+vsync.
    do_reset();
    idle(2);
    wr_cnt = 0;
    fd_cnt = 0;
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    for (int y = 0; y < H; y++) drive_line(y, W, (y % 2 == 1) ? 1 : 2, 1'b1);
    idle(1);
    cyc(1'b0, 2'd0, 1'b1, 1'b1);
    idle(4);
    check("frame_writes", 32'(wr_cnt), 32'd5760);
    check("frame_last_addr", 32'(last_a[12:0]), 32'h167F);
    check("frame_done_pulses", 32'(fd_cnt), 32'd1);
    check("frame_sync_err", 32'(sync_err), 32'd0);
    check("frame_pending", 32'(exp_q.size()), 32'd0);
`ifdef LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN
    check("display_page_after_frame", 32'(display_page), 32'd0);
    exp_page = 1'b1;
`endif

    // Short line then over-long line: line base realigns, excess pixels dropped.
    drive_line(0, 100, 2, 1'b1);
    idle(2);
    check("short_line_sync_err", 32'(sync_err), 32'd1);
    drive_line(1, W + 4, 2, 1'b1);
    idle(2);
    check("long_line_pending", 32'(exp_q.size()), 32'd0);
    cyc(1'b0, 2'd0, 1'b0, 1'b1);
    idle(4);
    check("early_vsync_no_done", 32'(fd_cnt), 32'd1);
    check("early_vsync_sync_err", 32'(sync_err), 32'd1);

    // Reset mid-line aborts everything and clears sync_err.
    cyc(1'b1, 2'd1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("abort_wr_n", 32'(fb_wr_n), 32'd1);
    check("abort_fb_A", 32'(fb_A), 32'd0);
    check("abort_fb_Do", 32'(fb_Do), 32'd0);
    check("abort_sync_err", 32'(sync_err), 32'd0);
    idle(2);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b1, 2'(i), 1'b0, 1'b0);
    idle(3);
    check("post_reset_sync_err", 32'(sync_err), 32'd0);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_frame_capture.md
LCD_FRAME_CAPTURE -- requirements
Module: lcd_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 160, visible pixels per line.
REQ-002 SHALL have parameter HEIGHT, default 144, visible lines per frame.
REQ-003 SHALL have ports: clock  in  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have ports: reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports: pixel_data  in  2  PPU shade, valid when pixel_latch=1.
REQ-006 SHALL have ports: pixel_latch  in  1  one-cycle strobe per pixel, same clock domain.
REQ-007 SHALL have ports: hsync  in  1  active-high end-of-line pulse, rising edge significant.
REQ-008 SHALL have ports: vsync  in  1  active-high end-of-frame pulse, rising edge significant.
REQ-009 SHALL have ports: fb_A  out  13 (14 with REQ-030 macro)  framebuffer byte address.
REQ-010 SHALL have ports: fb_Do  out  8  packed pixel byte.
REQ-011 SHALL have ports: fb_wr_n  out  1  active-low write strobe; fb_cs_n  out  1  active-low chip select, equal to fb_wr_n.
REQ-012 SHALL have ports: frame_done  out  1  one-cycle pulse on complete frame; sync_err  out  1  sticky geometry error.

Function
REQ-013 SHALL implement states WAIT_VSYNC, ACTIVE; reset enters WAIT_VSYNC; all pixel_latch and hsync ignored in WAIT_VSYNC.
REQ-014 SHALL transition WAIT_VSYNC -> ACTIVE on first vsync rising edge, with x=0, y=0, address=0.
REQ-015 SHALL detect hsync/vsync edges against a registered previous value (edge visible one cycle after input rises).
REQ-016 SHALL pack pixels MSB-first: 1st pixel of a group in fb_Do[7:6], 4th in [1:0].
REQ-017 SHALL, on the cycle after the 4th latched pixel of a group, drive fb_wr_n=fb_cs_n=0 for exactly one cycle with fb_A and fb_Do stable that cycle; outputs registered.
REQ-018 SHALL compute fb_A = y*(WIDTH/4) + x/4 via an incrementing counter (no multiplier); address increments after each write.
REQ-019 SHALL drop pixels with x >= WIDTH (no write) and set sync_err.
REQ-020 SHALL, on hsync edge in ACTIVE: if x != WIDTH set sync_err; clear x and partial group (partial bytes discarded); increment y; realign address to y*(WIDTH/4).
REQ-021 SHALL drop pixels and hsync-driven writes while y >= HEIGHT, setting sync_err on any dropped pixel.
REQ-022 SHALL, on vsync edge in ACTIVE: pulse frame_done next cycle iff y == HEIGHT, else set sync_err; then x=0, y=0, address=0.
REQ-023 SHALL process a pixel_latch coincident with an hsync or vsync edge as belonging to the current line before the line/frame advance.
REQ-024 SHALL give vsync priority over hsync when both edges coincide (no y increment; frame-end rules of REQ-022 apply).
REQ-025 SHALL clear sync_err only by reset.

Reset
REQ-026 SHALL, while reset_n=0, force fb_wr_n=1, fb_cs_n=1, fb_A=0, fb_Do=0, frame_done=0, sync_err=0, state WAIT_VSYNC, edge registers 0.
REQ-027 SHALL abort any in-progress line/frame on reset assertion; no write strobe SHALL be emitted during or in the cycle after release.

Configuration
REQ-028 SHALL honour macro LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN.
REQ-029 Without macro: fb_A is 13 bits, single buffer at 0x0000-0x167F.
REQ-030 With macro: fb_A is 14 bits, fb_A[13] is write page; page toggles on each frame_done; additional output display_page (1 bit, reset 1) equals the last completed page; write page resets to 0.

Verification
REQ-031 Reset then 160 pixels before any vsync -> no fb_wr_n strobe, sync_err=0.
REQ-032 vsync, then 4 pixels shades 3,2,1,0 -> one write fb_A=0x0000, fb_Do=0xE4, strobe one cycle after 4th latch.
REQ-033 vsync, full 144x160 frame with hsync per line, vsync -> 5760 writes, last fb_A=0x167F, frame_done single pulse, sync_err=0.
REQ-034 Line of 100 pixels then hsync -> sync_err=1, next line's first write at fb_A=0x0028.
REQ-035 pixel_latch coincident with hsync edge on 160th pixel -> byte written at line end address, no sync_err; coincident hsync+vsync -> y not incremented, frame_done per REQ-022.
REQ-036 With LCD_FRAME_CAPTURE_DOUBLE_BUFFER_EN: two full frames -> first frame writes 0x0000-0x167F, second 0x2000-0x367F, display_page 0 then 1.
